// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter sharing one up-counter between two requesters.
// The granted requester gets a len+1 cycle count, followed by a one-cycle done pulse.
module counter_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count_out,
  output logic [1:0]       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             last_served;
  logic             owner;
  logic             winner;
  logic [WIDTH-1:0] len_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_served;
    end else begin
      winner = req[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      busy        <= 1'b0;
      count_out   <= '0;
      done        <= '0;
      last_served <= 1'b1;
      owner       <= 1'b0;
      len_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner     <= winner;
            gnt       <= winner ? 2'b10 : 2'b01;
            len_q     <= winner ? len1 : len0;
            count_out <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            gnt         <= '0;
            busy        <= 1'b0;
            count_out   <= '0;
            last_served <= owner;
            state       <= IDLE;
          end else if (count_out == len_q) begin
            gnt         <= '0;
            done        <= owner ? 2'b10 : 2'b01;
            last_served <= owner;
            state       <= DONE;
          end else begin
            count_out <= count_out + WIDTH'(1);
          end
        end
        DONE: begin
          done      <= '0;
          busy      <= 1'b0;
          count_out <= '0;
          state     <= IDLE;
        end
        default: begin
          gnt       <= '0;
          busy      <= 1'b0;
          count_out <= '0;
          done      <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
